// File: rtl/ipv4_arp_result_ctrl.sv
// Pairs ARP lookup results with their next-hop IPv4 address and registers one forwarding decision per lookup.
// Optional feature macro: ARP_MISS_HOLDOFF_EN enables duplicate-miss suppression (timer, last_miss_ip, drop path).
module ipv4_arp_result_ctrl #(
  parameter int unsigned MAC_WIDTH          = 48,
  parameter int unsigned NH_FIFO_DEPTH_BITS = 2,
  parameter int unsigned HOLDOFF_CYCLES     = 1000,
  parameter int unsigned CNT_WIDTH          = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_lookup_valid,
  input  logic [31:0]          i_lookup_ipv4,
  input  logic                 i_arp_lut_valid,
  input  logic                 i_arp_lut_eth_addr_found,
  input  logic [MAC_WIDTH-1:0] i_arp_lut_eth_addr,
  output logic                 o_rd_arp_lut,
  output logic                 o_result_valid,
  output logic [MAC_WIDTH-1:0] o_result_eth_addr,
  output logic                 o_result_to_cpu,
  output logic                 o_result_drop,
  input  logic                 i_result_rd,
  output logic                 o_sync_err,
  output logic                 o_nh_overflow,
  input  logic                 i_cnt_clear,
  output logic [CNT_WIDTH-1:0] o_hit_cnt,
  output logic [CNT_WIDTH-1:0] o_miss_cnt,
  output logic [CNT_WIDTH-1:0] o_suppress_cnt
);

  localparam int unsigned NH_DEPTH = 1 << NH_FIFO_DEPTH_BITS;
  localparam int unsigned NH_CNT_W = NH_FIFO_DEPTH_BITS + 1;
  localparam logic [15:0] HOLDOFF_RELOAD = 16'(HOLDOFF_CYCLES);

  typedef enum logic {
    ST_EMPTY,
    ST_HOLD
  } state_e;

  // Reset: asynchronous assertion, deassertion synchronised to clk.
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_n;

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync_q <= '0;
    else         rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  logic [31:0]                   nh_mem_q [NH_DEPTH];
  logic [31:0]                   nh_mem_d [NH_DEPTH];
  logic [NH_FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [NH_FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [NH_CNT_W-1:0]           nh_cnt_q, nh_cnt_d;

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [MAC_WIDTH-1:0]  eth_q, eth_d;
  logic                  to_cpu_q, to_cpu_d;
  logic                  sync_err_q, sync_err_d;
  logic                  ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

`ifdef ARP_MISS_HOLDOFF_EN
  logic                  drop_q, drop_d;
  logic [CNT_WIDTH-1:0]  sup_cnt_q, sup_cnt_d;
  logic [15:0]           timer_q, timer_d;
  logic [31:0]           last_miss_ip_q, last_miss_ip_d;
  logic                  sup_inc;
`endif

  logic        lut_valid_g;
  logic        nh_empty;
  logic        nh_full;
  logic        reg_free;
  logic        pair;
  logic        sync_ev;
  logic        push;
  logic        ovf_ev;
  logic [31:0] nh_head;
  logic        hit_inc;
  logic        miss_inc;

  // LUT valid is masked while the synchronised reset is low so no pop leaks out.
  assign lut_valid_g  = i_arp_lut_valid & rst_n;
  assign nh_empty     = (nh_cnt_q == '0);
  assign nh_full      = (nh_cnt_q == NH_CNT_W'(NH_DEPTH));
  assign reg_free     = (state_q == ST_EMPTY) | i_result_rd;
  assign pair         = lut_valid_g & ~nh_empty & reg_free;
  assign sync_ev      = lut_valid_g &  nh_empty & reg_free;
  assign push         = i_lookup_valid & (~nh_full | pair);
  assign ovf_ev       = i_lookup_valid & nh_full & ~pair;
  assign nh_head      = nh_mem_q[rd_ptr_q];
  assign o_rd_arp_lut = pair | sync_ev;

  always_comb begin
    nh_mem_d = nh_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    nh_cnt_d = nh_cnt_q;
    if (push) begin
      nh_mem_d[wr_ptr_q] = i_lookup_ipv4;
      wr_ptr_d           = wr_ptr_q + 1'b1;
    end
    if (pair) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pair})
      2'b10:   nh_cnt_d = nh_cnt_q + 1'b1;
      2'b01:   nh_cnt_d = nh_cnt_q - 1'b1;
      default: nh_cnt_d = nh_cnt_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    eth_d    = eth_q;
    to_cpu_d = to_cpu_q;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
`ifdef ARP_MISS_HOLDOFF_EN
    drop_d         = drop_q;
    sup_inc        = 1'b0;
    last_miss_ip_d = last_miss_ip_q;
    timer_d        = (timer_q != '0) ? timer_q - 16'd1 : timer_q;
`endif
    if (pair) begin
      state_d = ST_HOLD;
      valid_d = 1'b1;
      if (i_arp_lut_eth_addr_found) begin
        eth_d    = i_arp_lut_eth_addr;
        to_cpu_d = 1'b0;
        hit_inc  = 1'b1;
`ifdef ARP_MISS_HOLDOFF_EN
        drop_d   = 1'b0;
`endif
      end else begin
        eth_d = '0;
`ifdef ARP_MISS_HOLDOFF_EN
        if ((nh_head == last_miss_ip_q) && (timer_q != '0)) begin
          to_cpu_d = 1'b0;
          drop_d   = 1'b1;
          sup_inc  = 1'b1;
        end else begin
          to_cpu_d       = 1'b1;
          drop_d         = 1'b0;
          miss_inc       = 1'b1;
          last_miss_ip_d = nh_head;
          timer_d        = HOLDOFF_RELOAD;
        end
`else
        to_cpu_d = 1'b1;
        miss_inc = 1'b1;
`endif
      end
    end else if ((state_q == ST_HOLD) && i_result_rd) begin
      state_d  = ST_EMPTY;
      valid_d  = 1'b0;
      eth_d    = '0;
      to_cpu_d = 1'b0;
`ifdef ARP_MISS_HOLDOFF_EN
      drop_d   = 1'b0;
`endif
    end
  end

  // Clear has priority over both sticky sets and counter increments.
  always_comb begin
    sync_err_d = sync_err_q | sync_ev;
    ovf_d      = ovf_q | ovf_ev;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_inc && (hit_cnt_q != '1))   hit_cnt_d  = hit_cnt_q + 1'b1;
    if (miss_inc && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 1'b1;
`ifdef ARP_MISS_HOLDOFF_EN
    sup_cnt_d = sup_cnt_q;
    if (sup_inc && (sup_cnt_q != '1))   sup_cnt_d  = sup_cnt_q + 1'b1;
`endif
    if (i_cnt_clear) begin
      sync_err_d = 1'b0;
      ovf_d      = 1'b0;
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
`ifdef ARP_MISS_HOLDOFF_EN
      sup_cnt_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NH_DEPTH; i++) nh_mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      nh_cnt_q   <= '0;
      state_q    <= ST_EMPTY;
      valid_q    <= 1'b0;
      eth_q      <= '0;
      to_cpu_q   <= 1'b0;
      sync_err_q <= 1'b0;
      ovf_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
`ifdef ARP_MISS_HOLDOFF_EN
      drop_q         <= 1'b0;
      sup_cnt_q      <= '0;
      timer_q        <= '0;
      last_miss_ip_q <= '0;
`endif
    end else begin
      nh_mem_q   <= nh_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      nh_cnt_q   <= nh_cnt_d;
      state_q    <= state_d;
      valid_q    <= valid_d;
      eth_q      <= eth_d;
      to_cpu_q   <= to_cpu_d;
      sync_err_q <= sync_err_d;
      ovf_q      <= ovf_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
`ifdef ARP_MISS_HOLDOFF_EN
      drop_q         <= drop_d;
      sup_cnt_q      <= sup_cnt_d;
      timer_q        <= timer_d;
      last_miss_ip_q <= last_miss_ip_d;
`endif
    end
  end

  assign o_result_valid    = valid_q;
  assign o_result_eth_addr = eth_q;
  assign o_result_to_cpu   = to_cpu_q;
  assign o_sync_err        = sync_err_q;
  assign o_nh_overflow     = ovf_q;
  assign o_hit_cnt         = hit_cnt_q;
  assign o_miss_cnt        = miss_cnt_q;

`ifdef ARP_MISS_HOLDOFF_EN
  assign o_result_drop  = drop_q;
  assign o_suppress_cnt = sup_cnt_q;
`else
  // Without suppression the stored next-hop address has no consumer.
  logic unused_nh_bits;
  assign unused_nh_bits = ^{nh_head, HOLDOFF_RELOAD};
  assign o_result_drop  = 1'b0;
  assign o_suppress_cnt = '0;
`endif

endmodule

// File: tb/tb_ipv4_arp_result_ctrl.sv
// Directed self-checking bench for ipv4_arp_result_ctrl (counters narrowed to 4 bits to reach saturation).
module tb_ipv4_arp_result_ctrl;

  localparam int unsigned MW = 48;
  localparam int unsigned CW = 4;

`ifdef ARP_MISS_HOLDOFF_EN
  localparam logic HOLDOFF = 1'b1;
`else
  localparam logic HOLDOFF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          i_lookup_valid;
  logic [31:0]   i_lookup_ipv4;
  logic          i_arp_lut_valid;
  logic          i_arp_lut_eth_addr_found;
  logic [MW-1:0] i_arp_lut_eth_addr;
  logic          o_rd_arp_lut;
  logic          o_result_valid;
  logic [MW-1:0] o_result_eth_addr;
  logic          o_result_to_cpu;
  logic          o_result_drop;
  logic          i_result_rd;
  logic          o_sync_err;
  logic          o_nh_overflow;
  logic          i_cnt_clear;
  logic [CW-1:0] o_hit_cnt;
  logic [CW-1:0] o_miss_cnt;
  logic [CW-1:0] o_suppress_cnt;

  int total = 0;
  int bad   = 0;

  ipv4_arp_result_ctrl #(
    .MAC_WIDTH          (MW),
    .NH_FIFO_DEPTH_BITS (2),
    .HOLDOFF_CYCLES     (1000),
    .CNT_WIDTH          (CW)
  ) dut (
    .clk                      (clk),
    .resetn                   (resetn),
    .i_lookup_valid           (i_lookup_valid),
    .i_lookup_ipv4            (i_lookup_ipv4),
    .i_arp_lut_valid          (i_arp_lut_valid),
    .i_arp_lut_eth_addr_found (i_arp_lut_eth_addr_found),
    .i_arp_lut_eth_addr       (i_arp_lut_eth_addr),
    .o_rd_arp_lut             (o_rd_arp_lut),
    .o_result_valid           (o_result_valid),
    .o_result_eth_addr        (o_result_eth_addr),
    .o_result_to_cpu          (o_result_to_cpu),
    .o_result_drop            (o_result_drop),
    .i_result_rd              (i_result_rd),
    .o_sync_err               (o_sync_err),
    .o_nh_overflow            (o_nh_overflow),
    .i_cnt_clear              (i_cnt_clear),
    .o_hit_cnt                (o_hit_cnt),
    .o_miss_cnt               (o_miss_cnt),
    .o_suppress_cnt           (o_suppress_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [31:0] ip);
    i_lookup_valid = 1'b1;
    i_lookup_ipv4  = ip;
    tick();
    i_lookup_valid = 1'b0;
  endtask

  task automatic lut_set(input logic v, input logic found, input logic [MW-1:0] mac);
    i_arp_lut_valid          = v;
    i_arp_lut_eth_addr_found = found;
    i_arp_lut_eth_addr       = mac;
  endtask

  task automatic clear_cnt();
    i_cnt_clear = 1'b1;
    tick();
    i_cnt_clear = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    i_lookup_valid = 1'b0; i_lookup_ipv4 = '0; i_result_rd = 1'b0; i_cnt_clear = 1'b0;
    lut_set(1'b0, 1'b0, '0);
    #2 resetn = 1'b0;
    lut_set(1'b1, 1'b1, 48'hAABBCCDDEEFF);
    tick(); tick();
    total++; if (o_result_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0h want 0", o_result_valid); end
    total++; if (o_result_eth_addr !== '0) begin bad++; $display("FAIL rst_eth: got %0h want 0", o_result_eth_addr); end
    total++; if (o_result_to_cpu !== 1'b0) begin bad++; $display("FAIL rst_to_cpu: got %0h want 0", o_result_to_cpu); end
    total++; if (o_result_drop !== 1'b0) begin bad++; $display("FAIL rst_drop: got %0h want 0", o_result_drop); end
    total++; if (o_rd_arp_lut !== 1'b0) begin bad++; $display("FAIL rst_rd_lut: got %0h want 0", o_rd_arp_lut); end
    total++; if (o_sync_err !== 1'b0) begin bad++; $display("FAIL rst_sync_err: got %0h want 0", o_sync_err); end
    total++; if (o_nh_overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %0h want 0", o_nh_overflow); end
    total++; if ({o_hit_cnt, o_miss_cnt, o_suppress_cnt} !== '0) begin bad++; $display("FAIL rst_cnts: got %0h/%0h/%0h want 0", o_hit_cnt, o_miss_cnt, o_suppress_cnt); end
    lut_set(1'b0, 1'b0, '0);
    resetn = 1'b1;
    tick(); tick(); tick();
    total++; if (o_result_valid !== 1'b0) begin bad++; $display("FAIL rst_rel_valid: got %0h want 0", o_result_valid); end
  endtask

  task automatic test_hit();
    clear_cnt();
    i_result_rd = 1'b0;
    do_push(32'h0A000001);
    total++; if (o_result_valid !== 1'b0) begin bad++; $display("FAIL hit_pre_valid: got %0h want 0", o_result_valid); end
    lut_set(1'b1, 1'b1, 48'h001122334455);
    #1;
    total++; if (o_rd_arp_lut !== 1'b1) begin bad++; $display("FAIL hit_pop: got %0h want 1", o_rd_arp_lut); end
    tick();
    lut_set(1'b0, 1'b0, '0);
    #1;
    total++; if (o_result_valid !== 1'b1) begin bad++; $display("FAIL hit_valid: got %0h want 1", o_result_valid); end
    total++; if (o_result_eth_addr !== 48'h001122334455) begin bad++; $display("FAIL hit_eth: got %0h want 001122334455", o_result_eth_addr); end
    total++; if (o_result_to_cpu !== 1'b0) begin bad++; $display("FAIL hit_to_cpu: got %0h want 0", o_result_to_cpu); end
    total++; if (o_result_drop !== 1'b0) begin bad++; $display("FAIL hit_drop: got %0h want 0", o_result_drop); end
    total++; if (o_hit_cnt !== 4'd1) begin bad++; $display("FAIL hit_cnt: got %0d want 1", o_hit_cnt); end
    total++; if (o_miss_cnt !== 4'd0) begin bad++; $display("FAIL hit_miss_cnt: got %0d want 0", o_miss_cnt); end
    total++; if (o_rd_arp_lut !== 1'b0) begin bad++; $display("FAIL hit_no_pop: got %0h want 0", o_rd_arp_lut); end
    i_result_rd = 1'b1;
    tick();
    total++; if (o_result_valid !== 1'b0) begin bad++; $display("FAIL hit_consumed: got %0h want 0", o_result_valid); end
  endtask

  task automatic test_dup_miss();
    logic       exp_cpu2, exp_drop2;
    logic [3:0] exp_miss2, exp_sup2, exp_miss3;
    exp_cpu2  = ~HOLDOFF;
    exp_drop2 = HOLDOFF;
    exp_miss2 = HOLDOFF ? 4'd1 : 4'd2;
    exp_sup2  = HOLDOFF ? 4'd1 : 4'd0;
    exp_miss3 = HOLDOFF ? 4'd2 : 4'd3;
    clear_cnt();
    i_result_rd = 1'b1;
    do_push(32'h0A000002);
    lut_set(1'b1, 1'b0, '0);
    tick();
    lut_set(1'b0, 1'b0, '0);
    total++; if ({o_result_valid, o_result_to_cpu, o_result_drop} !== 3'b110) begin bad++; $display("FAIL miss1_flags: got %b want 110", {o_result_valid, o_result_to_cpu, o_result_drop}); end
    total++; if (o_result_eth_addr !== '0) begin bad++; $display("FAIL miss1_eth: got %0h want 0", o_result_eth_addr); end
    tick(); tick(); tick();
    do_push(32'h0A000002);
    lut_set(1'b1, 1'b0, '0);
    tick();
    lut_set(1'b0, 1'b0, '0);
    total++; if ({o_result_valid, o_result_to_cpu, o_result_drop} !== {1'b1, exp_cpu2, exp_drop2}) begin bad++; $display("FAIL miss2_flags: got %b want %b", {o_result_valid, o_result_to_cpu, o_result_drop}, {1'b1, exp_cpu2, exp_drop2}); end
    total++; if (o_miss_cnt !== exp_miss2) begin bad++; $display("FAIL miss2_miss_cnt: got %0d want %0d", o_miss_cnt, exp_miss2); end
    total++; if (o_suppress_cnt !== exp_sup2) begin bad++; $display("FAIL miss2_sup_cnt: got %0d want %0d", o_suppress_cnt, exp_sup2); end
    repeat (1100) tick();
    do_push(32'h0A000002);
    lut_set(1'b1, 1'b0, '0);
    tick();
    lut_set(1'b0, 1'b0, '0);
    total++; if ({o_result_valid, o_result_to_cpu, o_result_drop} !== 3'b110) begin bad++; $display("FAIL miss3_flags: got %b want 110", {o_result_valid, o_result_to_cpu, o_result_drop}); end
    total++; if (o_miss_cnt !== exp_miss3) begin bad++; $display("FAIL miss3_miss_cnt: got %0d want %0d", o_miss_cnt, exp_miss3); end
    total++; if (o_suppress_cnt !== exp_sup2) begin bad++; $display("FAIL miss3_sup_cnt: got %0d want %0d", o_suppress_cnt, exp_sup2); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [MW-1:0] macs [4];
    int k;
    int pulses;
    macs[0] = 48'h0000000000A1; macs[1] = 48'h0000000000B2;
    macs[2] = 48'h0000000000C3; macs[3] = 48'h0000000000D4;
    k = 0;
    pulses = 0;
    clear_cnt();
    i_result_rd = 1'b0;
    for (int i = 0; i < 4; i++) do_push(32'h0A000010 + 32'(i));
    for (int c = 0; c < 10; c++) begin
      lut_set(1'b1, 1'b1, (k < 4) ? macs[k] : '0);
      #1;
      if (o_rd_arp_lut) begin pulses++; k++; end
      tick();
      total++; if ({o_result_valid, o_result_eth_addr} !== {1'b1, macs[0]}) begin bad++; $display("FAIL bp_hold_c%0d: got %b/%0h want 1/%0h", c, o_result_valid, o_result_eth_addr, macs[0]); end
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL bp_pulses: got %0d want 1", pulses); end
    i_result_rd = 1'b1;
    for (int j = 1; j < 4; j++) begin
      lut_set(1'b1, 1'b1, (k < 4) ? macs[k] : '0);
      #1;
      total++; if (o_rd_arp_lut !== 1'b1) begin bad++; $display("FAIL bp_rel_pop%0d: got %0h want 1", j, o_rd_arp_lut); end
      if (o_rd_arp_lut) k++;
      tick();
      total++; if ({o_result_valid, o_result_eth_addr} !== {1'b1, macs[j]}) begin bad++; $display("FAIL bp_rel_res%0d: got %b/%0h want 1/%0h", j, o_result_valid, o_result_eth_addr, macs[j]); end
    end
    lut_set(1'b0, 1'b0, '0);
    tick();
    total++; if (o_result_valid !== 1'b0) begin bad++; $display("FAIL bp_drained: got %0h want 0", o_result_valid); end
    total++; if (o_hit_cnt !== 4'd4) begin bad++; $display("FAIL bp_hit_cnt: got %0d want 4", o_hit_cnt); end
    i_result_rd = 1'b0;
  endtask

  task automatic test_overflow_sync();
    clear_cnt();
    i_result_rd = 1'b1;
    for (int i = 0; i < 4; i++) do_push(32'h0A000020 + 32'(i));
    total++; if (o_nh_overflow !== 1'b0) begin bad++; $display("FAIL ovf_at_full: got %0h want 0", o_nh_overflow); end
    i_lookup_valid = 1'b1; i_lookup_ipv4 = 32'h0A000024;
    lut_set(1'b1, 1'b1, 48'h000000000011);
    #1;
    total++; if (o_rd_arp_lut !== 1'b1) begin bad++; $display("FAIL ovf_pushpop_pop: got %0h want 1", o_rd_arp_lut); end
    tick();
    lut_set(1'b0, 1'b0, '0);
    total++; if (o_nh_overflow !== 1'b0) begin bad++; $display("FAIL ovf_pushpop: got %0h want 0", o_nh_overflow); end
    i_lookup_ipv4 = 32'h0A000025;
    tick();
    i_lookup_valid = 1'b0;
    total++; if (o_nh_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %0h want 1", o_nh_overflow); end
    for (int i = 0; i < 4; i++) begin
      lut_set(1'b1, 1'b1, 48'h000000000012 + 48'(i));
      #1;
      total++; if (o_rd_arp_lut !== 1'b1) begin bad++; $display("FAIL ovf_drain_pop%0d: got %0h want 1", i, o_rd_arp_lut); end
      tick();
    end
    lut_set(1'b0, 1'b0, '0);
    tick();
    total++; if (o_result_valid !== 1'b0) begin bad++; $display("FAIL sync_pre_valid: got %0h want 0", o_result_valid); end
    lut_set(1'b1, 1'b1, 48'h000000000099);
    #1;
    total++; if (o_rd_arp_lut !== 1'b1) begin bad++; $display("FAIL sync_pop: got %0h want 1", o_rd_arp_lut); end
    tick();
    lut_set(1'b0, 1'b0, '0);
    #1;
    total++; if (o_sync_err !== 1'b1) begin bad++; $display("FAIL sync_err: got %0h want 1", o_sync_err); end
    total++; if (o_result_valid !== 1'b0) begin bad++; $display("FAIL sync_valid: got %0h want 0", o_result_valid); end
    total++; if (o_hit_cnt !== 4'd5) begin bad++; $display("FAIL sync_hit_cnt: got %0d want 5", o_hit_cnt); end
    total++; if (o_rd_arp_lut !== 1'b0) begin bad++; $display("FAIL sync_single_pop: got %0h want 0", o_rd_arp_lut); end
    clear_cnt();
    total++; if ({o_sync_err, o_nh_overflow, o_hit_cnt} !== '0) begin bad++; $display("FAIL clear_sticky: got %b/%b/%0d want 0", o_sync_err, o_nh_overflow, o_hit_cnt); end
    i_result_rd = 1'b0;
  endtask

  task automatic test_saturation();
    clear_cnt();
    i_result_rd = 1'b1;
    for (int i = 0; i < 15; i++) begin
      do_push(32'h0A000100 + 32'(i));
      lut_set(1'b1, 1'b1, 48'h000000000100 + 48'(i));
      tick();
      lut_set(1'b0, 1'b0, '0);
    end
    total++; if (o_hit_cnt !== 4'hF) begin bad++; $display("FAIL sat_reach: got %0d want 15", o_hit_cnt); end
    do_push(32'h0A000200);
    lut_set(1'b1, 1'b1, 48'h000000000200);
    tick();
    lut_set(1'b0, 1'b0, '0);
    total++; if (o_hit_cnt !== 4'hF) begin bad++; $display("FAIL sat_hold: got %0d want 15", o_hit_cnt); end
    do_push(32'h0A000201);
    lut_set(1'b1, 1'b1, 48'h000000000201);
    i_cnt_clear = 1'b1;
    tick();
    i_cnt_clear = 1'b0;
    lut_set(1'b0, 1'b0, '0);
    total++; if (o_hit_cnt !== 4'd0) begin bad++; $display("FAIL sat_clear_wins: got %0d want 0", o_hit_cnt); end
    total++; if (o_result_eth_addr !== 48'h000000000201) begin bad++; $display("FAIL sat_clear_result: got %0h want 201", o_result_eth_addr); end
    tick();
    i_result_rd = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear_cnt();
    i_result_rd = 1'b0;
    for (int i = 0; i < 3; i++) do_push(32'h0A000300 + 32'(i));
    lut_set(1'b1, 1'b1, 48'h0000000003A0);
    tick();
    total++; if ({o_result_valid, o_result_eth_addr} !== {1'b1, 48'h0000000003A0}) begin bad++; $display("FAIL mid_hold: got %b/%0h want 1/3a0", o_result_valid, o_result_eth_addr); end
    resetn = 1'b0;
    #1;
    total++; if ({o_result_valid, o_result_to_cpu, o_result_drop, o_rd_arp_lut} !== 4'b0000) begin bad++; $display("FAIL mid_rst_flags: got %b want 0000", {o_result_valid, o_result_to_cpu, o_result_drop, o_rd_arp_lut}); end
    total++; if ({o_result_eth_addr, o_hit_cnt} !== '0) begin bad++; $display("FAIL mid_rst_data: got %0h/%0d want 0", o_result_eth_addr, o_hit_cnt); end
    tick();
    total++; if (o_rd_arp_lut !== 1'b0) begin bad++; $display("FAIL mid_rst_no_pop: got %0h want 0", o_rd_arp_lut); end
    lut_set(1'b0, 1'b0, '0);
    resetn = 1'b1;
    tick(); tick(); tick();
    lut_set(1'b1, 1'b1, 48'h0000000003B0);
    #1;
    total++; if (o_rd_arp_lut !== 1'b1) begin bad++; $display("FAIL mid_fifo_flushed_pop: got %0h want 1", o_rd_arp_lut); end
    tick();
    lut_set(1'b0, 1'b0, '0);
    total++; if ({o_sync_err, o_result_valid} !== 2'b10) begin bad++; $display("FAIL mid_fifo_flushed: got %b want 10", {o_sync_err, o_result_valid}); end
    clear_cnt();
    do_push(32'h0A000400);
    lut_set(1'b1, 1'b1, 48'h0000000004C0);
    tick();
    lut_set(1'b0, 1'b0, '0);
    total++; if ({o_result_valid, o_result_eth_addr} !== {1'b1, 48'h0000000004C0}) begin bad++; $display("FAIL mid_post_hit: got %b/%0h want 1/4c0", o_result_valid, o_result_eth_addr); end
    total++; if (o_hit_cnt !== 4'd1) begin bad++; $display("FAIL mid_post_cnt: got %0d want 1", o_hit_cnt); end
    i_result_rd = 1'b1;
    tick();
    i_result_rd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hit();
    test_dup_miss();
    test_back_to_back();
    test_overflow_sync();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
